// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: FSM state encoding,
// counter widths and the bundle of pipeline-register control strobes.
package pipeline_ctrl_pkg;

    localparam int unsigned STATE_W           = 2;
    localparam int unsigned LOAD_CNT_W        = 4;
    localparam int unsigned WDOG_W            = 8;
    localparam int unsigned CNT_WIDTH_DEFAULT = 32;

    localparam logic [STATE_W-1:0] RUN        = 2'd0;
    localparam logic [STATE_W-1:0] LOAD_STALL = 2'd1;
    localparam logic [STATE_W-1:0] MEM_WAIT   = 2'd2;

    // Write-enable / flush strobes for PC, IF/ID, ID/EX and EX/MEM+MEM/WB.
    typedef struct packed {
        logic pc_enable;
        logic if_id_enable;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_enable;
    } ctrl_t;

    localparam ctrl_t CTRL_ADVANCE = '{pc_enable: 1'b1, if_id_enable: 1'b1, if_id_flush: 1'b0,
                                       id_ex_flush: 1'b0, ex_mem_enable: 1'b1};
    localparam ctrl_t CTRL_FLUSH   = '{pc_enable: 1'b1, if_id_enable: 1'b1, if_id_flush: 1'b1,
                                       id_ex_flush: 1'b1, ex_mem_enable: 1'b1};
    localparam ctrl_t CTRL_STALL   = '{pc_enable: 1'b0, if_id_enable: 1'b0, if_id_flush: 1'b0,
                                       id_ex_flush: 1'b1, ex_mem_enable: 1'b1};
    localparam ctrl_t CTRL_FREEZE  = '{pc_enable: 1'b0, if_id_enable: 1'b0, if_id_flush: 1'b0,
                                       id_ex_flush: 1'b0, ex_mem_enable: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for performance statistics.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset (clears count)
//   inc   : increment request for this cycle
//   count : current value, holds at all-ones
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline stall/flush controller: load-use bubbles, memory-wait freeze with
// watchdog, branch flushes and saturating performance counters.
//   clk, reset (async active-low)
//   hazard, id_ex_mem_read, branch_taken, mem_request, mem_ready : inputs
//   pc_enable, if_id_enable, if_id_flush, id_ex_flush, ex_mem_enable :
//       combinational decode of state and inputs
//   mem_timeout_error : sticky watchdog flag
//   stall_cycles, flush_count : saturating counters
module pipeline_control_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT       = 255,
    parameter int unsigned CNT_WIDTH         = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hazard,
    input  logic                 id_ex_mem_read,
    input  logic                 branch_taken,
    input  logic                 mem_request,
    input  logic                 mem_ready,
    output logic                 pc_enable,
    output logic                 if_id_enable,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_enable,
    output logic                 mem_timeout_error,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);

    logic [STATE_W-1:0]    state_q, state_d;
    logic [LOAD_CNT_W-1:0] load_cnt_q, load_cnt_d;
    logic [WDOG_W-1:0]     wdog_q, wdog_d;
    logic                  err_q, err_d;
    ctrl_t                 ctrl_c;
    logic                  flush_inc_c;
    logic                  stall_inc_c;
    logic                  mem_stall_c;

    assign mem_stall_c = mem_request && !mem_ready;

    // Next-state and control decode.
    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        wdog_d      = wdog_q;
        err_d       = err_q;
        ctrl_c      = CTRL_ADVANCE;
        flush_inc_c = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_stall_c) begin
                    ctrl_c  = CTRL_FREEZE;
                    state_d = MEM_WAIT;
                    wdog_d  = '0;
                end else if (branch_taken) begin
                    // Branch squashes the younger instruction, so any load-use hazard is moot.
                    ctrl_c      = CTRL_FLUSH;
                    flush_inc_c = 1'b1;
                end else if (hazard && id_ex_mem_read) begin
                    ctrl_c = CTRL_STALL;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d    = LOAD_STALL;
                        load_cnt_d = LOAD_CNT_W'(LOAD_STALL_CYCLES - 1);
                    end
                end
            end
            LOAD_STALL: begin
                if (mem_stall_c) begin
                    // Remaining bubbles are dropped; the hazard is re-checked in RUN.
                    ctrl_c     = CTRL_FREEZE;
                    state_d    = MEM_WAIT;
                    wdog_d     = '0;
                    load_cnt_d = '0;
                end else begin
                    ctrl_c     = CTRL_STALL;
                    load_cnt_d = load_cnt_q - LOAD_CNT_W'(1);
                    if (load_cnt_q == LOAD_CNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
            end
            MEM_WAIT: begin
                ctrl_c = CTRL_FREEZE;
                if (mem_ready) begin
                    state_d = RUN;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                    if ((wdog_q + WDOG_W'(1)) == WDOG_W'(MEM_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            load_cnt_q <= '0;
            wdog_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            wdog_q     <= wdog_d;
            err_q      <= err_d;
        end
    end

    assign stall_inc_c = !ctrl_c.pc_enable;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc_c),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc_c),
        .count (flush_count)
    );

    assign pc_enable         = ctrl_c.pc_enable;
    assign if_id_enable      = ctrl_c.if_id_enable;
    assign if_id_flush       = ctrl_c.if_id_flush;
    assign id_ex_flush       = ctrl_c.id_ex_flush;
    assign ex_mem_enable     = ctrl_c.ex_mem_enable;
    assign mem_timeout_error = err_q;

endmodule
